accel_msg_scheduler: RTL and testbench

SHA-256 message scheduler: the producer end of the compressor's `w` word input. It captures one 512-bit message block and emits W[0..63], one 32-bit word per cycle. The output timing lines up with the compressor's HASH round counter when both blocks are started in the same cycle. It sits beside the compressor in the hashing core, driven by the same control that pulses cm_enable.

---
 rtl/accel_msg_scheduler.sv | 104 ++++++++++
 tb/tb_accel_msg_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/accel_msg_scheduler.sv
// SHA-256 message scheduler: captures a 512-bit block and streams W[0..63],
// one word per cycle, aligned with the compressor's round counter.
`timescale 1ns/1ps
module accel_msg_scheduler #(
  parameter int LEAD = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sch_start,
  input  logic         sch_abort,
  input  logic [511:0] block_in,
  output logic [31:0]  w_out,
  output logic         w_valid,
  output logic         sch_busy,
  output logic         sch_done
);

  typedef enum logic [1:0] {IDLE, ALIGN, GEN, DONE} state_e;

  localparam logic [1:0] LEAD_LAST = (LEAD > 0) ? 2'(LEAD - 1) : 2'd0;

  state_e      state_q, state_d;
  logic [6:0]  t_q, t_d;
  logic [1:0]  dly_q, dly_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic        w_valid_q, w_valid_d;
  logic        sch_busy_q, sch_busy_d;
  logic        sch_done_q, sch_done_d;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    t_d     = t_q;
    dly_d   = dly_q;
    win_d   = win_q;

    unique case (state_q)
      IDLE: begin
        if (sch_start) begin
          for (int j = 0; j < 16; j++) win_d[j] = block_in[511 - 32*j -: 32];
          t_d     = 7'd0;
          dly_d   = 2'd0;
          state_d = (LEAD > 0) ? ALIGN : GEN;
        end
      end
      ALIGN: begin
        if (dly_q == LEAD_LAST) state_d = GEN;
        else                    dly_d   = dly_q + 2'd1;
      end
      GEN: begin
        // Slide the window; the tail word is W[t+16] from the four taps.
        for (int j = 0; j < 15; j++) win_d[j] = win_q[j+1];
        win_d[15] = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
        if (t_q == 7'd63) state_d = DONE;
        else              t_d     = t_q + 7'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (sch_abort) state_d = IDLE;

    w_valid_d  = (state_d == GEN);
    sch_busy_d = (state_d != IDLE);
    sch_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      t_q        <= 7'd0;
      dly_q      <= 2'd0;
      // NOTE: the window is reset deliberately so outputs and state are fully defined out of reset.
      for (int j = 0; j < 16; j++) win_q[j] <= 32'd0;
      w_valid_q  <= 1'b0;
      sch_busy_q <= 1'b0;
      sch_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q    <= state_d;
      t_q        <= t_d;
      dly_q      <= dly_d;
      win_q      <= win_d;
      w_valid_q  <= w_valid_d;
      sch_busy_q <= sch_busy_d;
      sch_done_q <= sch_done_d;
    end
  end

  assign w_out    = w_valid_q ? win_q[0] : 32'd0;
  assign w_valid  = w_valid_q;
  assign sch_busy = sch_busy_q;
  assign sch_done = sch_done_q;

endmodule

// File: tb/tb_accel_msg_scheduler.sv
// Bench for accel_msg_scheduler: LEAD=0 and LEAD=1 instances share stimulus and
// are compared every cycle against a timeline model built from the textbook schedule.
`timescale 1ns/1ps
module tb_accel_msg_scheduler;

  localparam logic [511:0] ABC = {32'h61626380, 448'd0, 32'h00000018};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sch_start = 1'b0;
  logic         sch_abort = 1'b0;
  logic [511:0] block_in = '0;

  logic [31:0] w_out_l0, w_out_l1;
  logic        w_valid_l0, w_valid_l1, busy_l0, busy_l1, done_l0, done_l1;

  accel_msg_scheduler #(.LEAD(0)) u_lead0 (
    .clk(clk), .rst_n(rst_n), .sch_start(sch_start), .sch_abort(sch_abort),
    .block_in(block_in), .w_out(w_out_l0), .w_valid(w_valid_l0),
    .sch_busy(busy_l0), .sch_done(done_l0)
  );

  accel_msg_scheduler #(.LEAD(1)) u_lead1 (
    .clk(clk), .rst_n(rst_n), .sch_start(sch_start), .sch_abort(sch_abort),
    .block_in(block_in), .w_out(w_out_l1), .w_valid(w_valid_l1),
    .sch_busy(busy_l1), .sch_done(done_l1)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          lead [2] = '{0, 1};
  int          k [2] = '{0, 0};      // cycles since acceptance; 0 = idle
  bit          abc_run [2] = '{1'b0, 1'b0};
  logic [31:0] wref [2][64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void gen_ref(input int d, input logic [511:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) wref[d][t] = blk[511 - 32*t -: 32];
      else wref[d][t] = (rotr(wref[d][t-2], 17) ^ rotr(wref[d][t-2], 19) ^ (wref[d][t-2] >> 10))
                      + wref[d][t-7]
                      + (rotr(wref[d][t-15], 7) ^ rotr(wref[d][t-15], 18) ^ (wref[d][t-15] >> 3))
                      + wref[d][t-16];
    end
  endfunction

  function automatic bit abc_known(input int t, output logic [31:0] v);
    abc_known = 1'b1;
    case (t)
      0:       v = 32'h61626380;
      16:      v = 32'h61626380;
      17:      v = 32'h000F0000;
      18:      v = 32'h7DA86405;
      19:      v = 32'h600003C6;
      63:      v = 32'h12B1EDEB;
      default: begin v = 32'd0; abc_known = 1'b0; end
    endcase
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] w, kv;
      logic        v, b, dn, ev;
      string       p;
      w  = (d == 0) ? w_out_l0   : w_out_l1;
      v  = (d == 0) ? w_valid_l0 : w_valid_l1;
      b  = (d == 0) ? busy_l0    : busy_l1;
      dn = (d == 0) ? done_l0    : done_l1;
      p  = $sformatf("L%0d k=%0d", lead[d], k[d]);
      ev = (k[d] >= lead[d] + 1) && (k[d] <= lead[d] + 64);
      check({p, " w_valid"}, 32'(v), 32'(ev));
      check({p, " w_out"}, w, ev ? wref[d][k[d] - lead[d] - 1] : 32'd0);
      check({p, " sch_busy"}, 32'(b), 32'(k[d] != 0));
      check({p, " sch_done"}, 32'(dn), 32'(k[d] == lead[d] + 65));
      if (ev && abc_run[d] && abc_known(k[d] - lead[d] - 1, kv))
        check($sformatf("L%0d abc W%0d", lead[d], k[d] - lead[d] - 1), w, kv);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || sch_abort) k[d] = 0;
      else if (k[d] == 0) begin
        if (sch_start) begin
          k[d] = 1;
          gen_ref(d, block_in);
          abc_run[d] = (block_in == ABC);
        end
      end else begin
        k[d] = k[d] + 1;
        if (k[d] > lead[d] + 65) k[d] = 0;
      end
    end
    #1;
    check_all();
  endtask

  task automatic run_until(input int d, input int target, input int limit);
    int n = 0;
    while (k[d] != target) begin
      if (n == limit) begin
        n_err++;
        $display("FAIL timeout L%0d waiting k=%0d got=%0d", lead[d], target, k[d]);
        return;
      end
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) step();

    // "abc" block; a second start mid-stream is ignored.
    block_in = ABC; sch_start = 1'b1;
    step();
    sch_start = 1'b0; block_in = rand_block();
    repeat (30) step();
    sch_start = 1'b1; block_in = rand_block();
    step();
    sch_start = 1'b0;
    run_until(1, 0, 100);

    // Restart in the first idle cycle, then abort at t=20.
    block_in = ABC; sch_start = 1'b1;
    step();
    sch_start = 1'b0; block_in = rand_block();
    run_until(1, lead[1] + 1 + 20, 100);
    sch_abort = 1'b1;
    step();
    sch_abort = 1'b0;
    repeat (3) step();

    // Fresh "abc" after the abort must reproduce the full stream.
    block_in = ABC; sch_start = 1'b1;
    step();
    sch_start = 1'b0;
    run_until(1, 0, 100);
    run_until(0, 0, 100);

    // Abort and start together in IDLE: the start is dropped.
    sch_start = 1'b1; sch_abort = 1'b1; block_in = rand_block();
    step();
    sch_start = 1'b0; sch_abort = 1'b0;
    step();

    // Asynchronous reset mid-GEN.
    block_in = rand_block(); sch_start = 1'b1;
    step();
    sch_start = 1'b0;
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    k = '{0, 0};
    check("async rst w_out L1", w_out_l1, 32'd0);
    check("async rst w_valid L1", 32'(w_valid_l1), 32'd0);
    check("async rst busy L1", 32'(busy_l1), 32'd0);
    check("async rst w_out L0", w_out_l0, 32'd0);
    check("async rst busy L0", 32'(busy_l0), 32'd0);
    sch_start = 1'b1;
    step();
    sch_start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) step();

    // Randomized traffic: random starts, rare aborts, block_in churning every cycle.
    for (int c = 0; c < 3000; c++) begin
      sch_start = ($urandom_range(0, 7) == 0);
      sch_abort = ($urandom_range(0, 149) == 0);
      block_in  = ($urandom_range(0, 9) == 0) ? ABC : rand_block();
      step();
    end
    sch_start = 1'b0; sch_abort = 1'b0;
    repeat (70) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
